// File: rtl/add_arb4_pkg.sv
// Shared defaults and types for the 4-requester arbitrated adder.
// Widths and the requester index type live here so the top and the picker agree.
package add_arb4_pkg;

  localparam int unsigned W_DEF        = 12;
  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned LOR_BITS_DEF = 4;
  localparam int unsigned CNT_W        = 16;

  typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin 4-way picker: grants the first valid requester at or after i_ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_pick4
  import add_arb4_pkg::*;
(
  input  logic [3:0] i_valid,
  input  req_idx_t   i_ptr,
  output logic [3:0] o_grant,
  output req_idx_t   o_idx,
  output logic       o_any
);

  req_idx_t w_cand;
  logic     w_found;

  always_comb begin
    w_cand  = i_ptr;
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 0; k < 4; k++) begin
      w_cand = i_ptr + req_idx_t'(k);
      if (!w_found && i_valid[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_idx            = w_cand;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/add_arb4.sv
// Four requesters share one adder (exact or lower-part-OR approximate) through a
// round-robin arbiter feeding a single result register with ready/valid handshake.
module add_arb4
  import add_arb4_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned LOR_BITS = LOR_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_approx,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic               res_cout,
  output logic [1:0]         res_id,
  output logic [CNT_W-1:0]   op_count
);

  localparam int unsigned HiW = W - LOR_BITS;

  req_idx_t           r_ptr;
  logic               r_res_valid;
  logic [W-1:0]       r_res_sum;
  logic               r_res_cout;
  req_idx_t           r_res_id;
  logic [CNT_W-1:0]   r_op_count;

  logic [3:0]         w_grant;
  req_idx_t           w_idx;
  logic               w_any;
  logic               w_slot_free;
  logic               w_grant_en;
  logic               w_retire;
  logic [W-1:0]       w_a;
  logic [W-1:0]       w_b;
  logic               w_cin;
  logic [W:0]         w_exact;
  logic [HiW:0]       w_hi;
  logic [W-1:0]       w_sum;
  logic               w_cout;

  rr_pick4 u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_slot_free = !r_res_valid || res_ready;
  // Reset gates the grant so no requester sees an accept that would be discarded.
  assign w_grant_en  = w_slot_free && w_any && !rst;
  assign w_retire    = r_res_valid && res_ready;
  assign req_ready   = w_grant_en ? w_grant : '0;

  always_comb begin
    w_a   = req_a[int'(w_idx)*W +: W];
    w_b   = req_b[int'(w_idx)*W +: W];
    w_cin = req_cin[w_idx];
  end

  always_comb begin
    w_exact = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};
    // Upper part takes its carry from the AND of the top approximate bits.
    w_hi    = {1'b0, w_a[W-1:LOR_BITS]} + {1'b0, w_b[W-1:LOR_BITS]}
            + {{HiW{1'b0}}, w_a[LOR_BITS-1] & w_b[LOR_BITS-1]};
    if (cfg_approx) begin
      w_sum  = {w_hi[HiW-1:0], w_a[LOR_BITS-1:0] | w_b[LOR_BITS-1:0]};
      w_cout = w_hi[HiW];
    end else begin
      w_sum  = w_exact[W-1:0];
      w_cout = w_exact[W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant_en) begin
      r_ptr <= w_idx + req_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= '0;
    end else if (w_grant_en) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_sum;
      r_res_cout  <= w_cout;
      r_res_id    <= w_idx;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_retire && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_id    = r_res_id;
  assign op_count  = r_op_count;

endmodule

// File: doc/add_arb4.md
ADD_ARB4 -- requirements
Module: add_arb4

Interface
REQ-001 Parameter W, default 12, operand/sum width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-003 Parameter LOR_BITS, default 4, width of the approximate lower part (1..W-1).
REQ-004 clk  input  1  rising-edge clock; sole clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_approx  input  1  1 = lower-part-OR approximate add, 0 = exact add; sampled per grant.
REQ-007 req_valid  input  N_REQ  per-requester operand valid.
REQ-008 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-009 req_a  input  N_REQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-010 req_b  input  N_REQ*W  packed operand B, same packing.
REQ-011 req_cin  input  N_REQ  per-requester carry-in.
REQ-012 res_valid  output  1  result register holds a valid result.
REQ-013 res_ready  input  1  downstream accepts the result.
REQ-014 res_sum  output  W  registered sum.
REQ-015 res_cout  output  1  registered carry-out.
REQ-016 res_id  output  2  index of the requester that owns the result.
REQ-017 op_count  output  16  saturating count of completed result transfers.

Function
REQ-018 slot_free = !res_valid || res_ready; no grant is issued when slot_free = 0.
REQ-019 When slot_free = 1 and any req_valid is high, exactly one req_ready bit is asserted, the round-robin winner; req_ready is combinational from req_valid, the pointer, res_valid and res_ready.
REQ-020 Round-robin order: the search starts at ptr, then ptr+1 mod 4, and so on. After a grant to index g, ptr becomes (g+1) mod 4. Without a grant, ptr holds.
REQ-021 A transfer occurs when req_valid[g] && req_ready[g]. The result is visible on the next rising edge with res_valid = 1, giving 1-cycle latency.
REQ-022 Exact mode: {res_cout, res_sum} = a + b + cin, computed at width W+1.
REQ-023 Approximate mode, lower part: res_sum[LOR_BITS-1:0] = a | b (bitwise, same bit range); cin is ignored.
REQ-024 Approximate mode, upper part: {res_cout, res_sum[W-1:LOR_BITS]} = a_hi + b_hi + (a[LOR_BITS-1] & b[LOR_BITS-1]).
REQ-025 The mode is latched with the operands at grant; a cfg_approx change never alters a held result.
REQ-026 res_sum, res_cout and res_id remain stable while res_valid && !res_ready.
REQ-027 Simultaneous res_ready = 1 and a new grant: the old result retires and the new one loads on the same edge, giving full throughput of 1 op/cycle.
REQ-028 If res_ready = 1 and there is no grant, res_valid falls to 0 on the next edge.
REQ-029 op_count increments on each res_valid && res_ready edge and saturates at 0xFFFF.
REQ-030 A requester dropping req_valid without a transfer is not granted and does not advance ptr.

Reset
REQ-031 While rst = 1: res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, op_count = 0, ptr = 0.
REQ-032 Reset asserted mid-operation discards any held result without a transfer. req_ready is 0 in every cycle rst is high.
REQ-033 In the first cycle after reset, ptr = 0, so requester 0 has priority.

Structure
REQ-034 A shared package holds W, N_REQ and LOR_BITS defaults and the requester-index type (2 bits).
REQ-035 One sub-module, rr_pick4, is natural: inputs are the valid vector and ptr; outputs are the one-hot grant and the winner index.
REQ-036 The adder datapath is combinational inside add_arb4 and feeds a single result register stage.

Verification
REQ-037 Exact, cfg_approx = 0: a = 0x0FF, b = 0x001, cin = 0 -> res_sum = 0x100, res_cout = 0, one cycle after the grant.
REQ-038 Exact overflow: a = 0xFFF, b = 0x001, cin = 0 -> res_sum = 0x000, res_cout = 1.
REQ-039 Approximate, LOR_BITS = 4: a = 0x00F, b = 0x001 -> res_sum = 0x00F. Also a = 0x018, b = 0x008 -> res_sum = 0x028.
REQ-040 Round-robin: all four req_valid high from the first cycle after reset, res_ready = 1 -> res_id sequence 0, 1, 2, 3, 0 on consecutive cycles, with op_count tracking transfers.
REQ-041 Backpressure: one grant, then res_ready = 0 for 5 cycles -> req_ready = 0000 and the result is held stable; when res_ready = 1 the result retires and the next requester is granted in the same cycle.
REQ-042 Reset mid-operation: rst pulsed while res_valid = 1 -> res_valid = 0 and op_count = 0 the next cycle, and the first grant after reset goes to requester 0.
